// File: rtl/uart_cmd_pkg.sv
// Shared constants for the ASCII UART bus command master: protocol characters and FSM encoding.
// Optional address cache is enabled by defining UART_CMD_MASTER_ADDR_CACHE_EN.
package uart_cmd_pkg;

  localparam logic [7:0] CHAR_L     = 8'h4c;  // 'L'
  localparam logic [7:0] CHAR_W     = 8'h57;  // 'W'
  localparam logic [7:0] CHAR_R     = 8'h52;  // 'R'
  localparam logic [7:0] CHAR_COMMA = 8'h2c;  // ',' target reset asserted
  localparam logic [7:0] CHAR_DOT   = 8'h2e;  // '.' target reset released
  localparam logic [7:0] CHAR_0     = 8'h30;  // '0'
  localparam logic [7:0] CHAR_A     = 8'h61;  // 'a'

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_RST_CHAR = 4'd1;
  localparam state_t ST_CMD_L    = 4'd2;
  localparam state_t ST_ADDR     = 4'd3;
  localparam state_t ST_CMD_W    = 4'd4;
  localparam state_t ST_DATA     = 4'd5;
  localparam state_t ST_CMD_R    = 4'd6;
  localparam state_t ST_RX_HI    = 4'd7;
  localparam state_t ST_RX_LO    = 4'd8;
  localparam state_t ST_ACK      = 4'd9;

endpackage

// File: rtl/uart_hex_codec.sv
// Combinational lowercase hex codec: nibble to ASCII for transmit, ASCII to nibble for receive.
module uart_hex_codec
  import uart_cmd_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_char,
  input  logic [7:0] i_char,
  output logic [3:0] o_nib,
  output logic       o_valid
);

  always_comb begin
    if (i_nib <= 4'd9) begin
      o_char = CHAR_0 + {4'h0, i_nib};
    end else begin
      o_char = (CHAR_A - 8'd10) + {4'h0, i_nib};
    end
  end

  // Uppercase hex is deliberately rejected; the protocol is lowercase only.
  always_comb begin
    o_nib   = 4'h0;
    o_valid = 1'b0;
    if (i_char >= CHAR_0 && i_char <= (CHAR_0 + 8'd9)) begin
      o_nib   = i_char[3:0];
      o_valid = 1'b1;
    end else if (i_char >= CHAR_A && i_char <= (CHAR_A + 8'd5)) begin
      o_nib   = i_char[3:0] + 4'd9;
      o_valid = 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_master.sv
// Bus-to-ASCII UART command initiator: sends L<aaaa>W<dd> / L<aaaa>R and decodes the hex reply.
// Define UART_CMD_MASTER_ADDR_CACHE_EN to skip the address phase on sequential accesses.
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_dat,
  output logic [7:0]  o_dat,
  output logic        o_ack,
  output logic        o_err,
  input  logic        i_target_reset,
  input  logic        i_uart_send_ready,
  output logic        o_uart_send_pulse,
  output logic [7:0]  o_uart_dat,
  input  logic        i_uart_received_pulse,
  input  logic [7:0]  i_uart_dat
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 32'd1);

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_idx;
  logic [31:0] r_cnt;
  logic        r_we;
  logic [15:0] r_addr;
  logic [7:0]  r_wdat;
  logic [7:0]  r_dat;
  logic        r_err;
  logic [3:0]  r_rx_hi;
  logic        r_rst_sent;
  logic        r_rst_lvl;

  logic [3:0]  w_tx_nib;
  logic [7:0]  w_hex_char;
  logic [3:0]  w_rx_nib;
  logic        w_rx_valid;
  logic        w_rx_ok;
  logic        w_in_rx;
  logic        w_tmo;
  logic        w_tmo_fire;
  logic        w_done_ok;
  logic        w_tx_state;
  logic        w_rst_go;
  logic        w_accept;
  logic        w_hit;

  uart_hex_codec u_codec (
    .i_nib   (w_tx_nib),
    .o_char  (w_hex_char),
    .i_char  (i_uart_dat),
    .o_nib   (w_rx_nib),
    .o_valid (w_rx_valid)
  );

  assign w_rx_ok    = i_uart_received_pulse & w_rx_valid;
  assign w_in_rx    = (r_state == ST_RX_HI) || (r_state == ST_RX_LO);
  assign w_tmo      = (TIMEOUT != 0) && (r_cnt == TMO_LAST);
  assign w_tmo_fire = w_in_rx && !w_rx_ok && w_tmo;
  assign w_done_ok  = ((r_state == ST_DATA) && i_uart_send_ready && (r_idx == 2'd1)) ||
                      ((r_state == ST_RX_LO) && w_rx_ok);
  assign w_rst_go   = (r_state == ST_IDLE) && (i_target_reset != r_rst_sent);
  assign w_accept   = (r_state == ST_IDLE) && !w_rst_go && i_req;

`ifdef UART_CMD_MASTER_ADDR_CACHE_EN
  logic [15:0] r_next_addr;
  logic        r_cache_vld;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_next_addr <= 16'h0000;
      r_cache_vld <= 1'b0;
    end else if (w_done_ok) begin
      r_next_addr <= r_addr + 16'd1;
      r_cache_vld <= 1'b1;
    end else if (w_tmo_fire || ((r_state == ST_RST_CHAR) && i_uart_send_ready)) begin
      r_cache_vld <= 1'b0;
    end
  end

  assign w_hit = r_cache_vld && (i_addr == r_next_addr);
`else
  assign w_hit = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rst_go) begin
          w_state_next = ST_RST_CHAR;
        end else if (i_req) begin
          if (w_hit) begin
            w_state_next = i_we ? ST_CMD_W : ST_CMD_R;
          end else begin
            w_state_next = ST_CMD_L;
          end
        end
      end
      ST_RST_CHAR: if (i_uart_send_ready) w_state_next = ST_IDLE;
      ST_CMD_L:    if (i_uart_send_ready) w_state_next = ST_ADDR;
      ST_ADDR: begin
        if (i_uart_send_ready && (r_idx == 2'd3)) begin
          w_state_next = r_we ? ST_CMD_W : ST_CMD_R;
        end
      end
      ST_CMD_W:    if (i_uart_send_ready) w_state_next = ST_DATA;
      ST_DATA:     if (i_uart_send_ready && (r_idx == 2'd1)) w_state_next = ST_ACK;
      ST_CMD_R:    if (i_uart_send_ready) w_state_next = ST_RX_HI;
      ST_RX_HI: begin
        if (w_rx_ok) begin
          w_state_next = ST_RX_LO;
        end else if (w_tmo) begin
          w_state_next = ST_ACK;
        end
      end
      ST_RX_LO:    if (w_rx_ok || w_tmo) w_state_next = ST_ACK;
      ST_ACK:      w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx_nib = 4'h0;
    if (r_state == ST_ADDR) begin
      case (r_idx)
        2'd0:    w_tx_nib = r_addr[15:12];
        2'd1:    w_tx_nib = r_addr[11:8];
        2'd2:    w_tx_nib = r_addr[7:4];
        default: w_tx_nib = r_addr[3:0];
      endcase
    end else if (r_state == ST_DATA) begin
      w_tx_nib = r_idx[0] ? r_wdat[3:0] : r_wdat[7:4];
    end
  end

  always_comb begin
    w_tx_state = 1'b1;
    o_uart_dat = 8'h00;
    case (r_state)
      ST_RST_CHAR: o_uart_dat = r_rst_lvl ? CHAR_COMMA : CHAR_DOT;
      ST_CMD_L:    o_uart_dat = CHAR_L;
      ST_ADDR:     o_uart_dat = w_hex_char;
      ST_CMD_W:    o_uart_dat = CHAR_W;
      ST_DATA:     o_uart_dat = w_hex_char;
      ST_CMD_R:    o_uart_dat = CHAR_R;
      default:     w_tx_state = 1'b0;
    endcase
  end

  assign o_uart_send_pulse = w_tx_state & i_uart_send_ready;
  assign o_ack             = (r_state == ST_ACK);
  assign o_err             = (r_state == ST_ACK) & r_err;
  assign o_dat             = r_dat;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_cnt   <= 32'd0;
    end else begin
      r_state <= w_state_next;
      // Nibble index and timeout counter both restart on every state change.
      if (w_state_next != r_state) begin
        r_idx <= 2'd0;
        r_cnt <= 32'd0;
      end else begin
        if (((r_state == ST_ADDR) || (r_state == ST_DATA)) && i_uart_send_ready) begin
          r_idx <= r_idx + 2'd1;
        end
        if (w_in_rx) begin
          r_cnt <= r_cnt + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_we       <= 1'b0;
      r_addr     <= 16'h0000;
      r_wdat     <= 8'h00;
      r_dat      <= 8'h00;
      r_err      <= 1'b0;
      r_rx_hi    <= 4'h0;
      r_rst_sent <= 1'b0;
      r_rst_lvl  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we   <= i_we;
        r_addr <= i_addr;
        r_wdat <= i_dat;
      end
      if (w_rst_go) begin
        r_rst_lvl <= i_target_reset;
      end
      if ((r_state == ST_RST_CHAR) && i_uart_send_ready) begin
        r_rst_sent <= r_rst_lvl;
      end
      if ((r_state == ST_RX_HI) && w_rx_ok) begin
        r_rx_hi <= w_rx_nib;
      end
      if (w_done_ok) begin
        r_err <= 1'b0;
        if (r_state == ST_RX_LO) begin
          r_dat <= {r_rx_hi, w_rx_nib};
        end
      end else if (w_tmo_fire) begin
        r_err <= 1'b1;
        r_dat <= 8'hff;
      end
    end
  end

endmodule

// File: doc/uart_cmd_master.md
# uart_cmd_master

Host-side initiator for the ASCII UART bus protocol: converts 8-bit-data / 16-bit-address bus requests into command strings (`L<aaaa>W<dd>`, `L<aaaa>R`), sends them through a UART transmitter, and decodes the two-hex-character read reply from a UART receiver. It sits between a local bus master (CPU, test sequencer) and the UART core, driving a remote target over the serial link. It also forwards a target-reset level as `,` or `.`.

## Interface
- TIMEOUT, default 100000: clock cycles to wait for each read-reply character; 0 disables the timeout.
- i_clk  in  1  clock; all logic on the rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_req  in  1  bus request; held high until o_ack
- i_we  in  1  1 = write, 0 = read; sampled with i_req
- i_addr  in  16  target address
- i_dat  in  8  write data
- o_dat  out  8  read data; held until the next read completes
- o_ack  out  1  one-cycle completion pulse
- o_err  out  1  valid with o_ack; 1 = read timed out
- i_target_reset  in  1  requested target reset level (1 = asserted)
- i_uart_send_ready  in  1  transmitter can accept a character
- o_uart_send_pulse  out  1  send o_uart_dat this cycle
- o_uart_dat  out  8  character to send
- i_uart_received_pulse  in  1  receiver has a character
- i_uart_dat  in  8  received character

## Operation
- Reset values: o_ack=0, o_err=0, o_dat=0x00, o_uart_send_pulse=0. FSM goes to IDLE. Sent-reset state = 0 (released). Address cache invalid.
- FSM states:
  - IDLE
  - RST_CHAR: one `,` or `.`
  - CMD_L
  - ADDR: 4 nibbles, most significant first
  - CMD_W
  - DATA: 2 nibbles, high nibble first
  - CMD_R
  - RX_HI
  - RX_LO
  - ACK
- IDLE priority, highest first:
  - If i_target_reset differs from the sent state, go to RST_CHAR. Send `,` if i_target_reset=1, else `.`, then update the sent state.
  - Otherwise, if i_req=1, latch i_we, i_addr and i_dat, then go to CMD_L. With the cache enabled, go directly to CMD_W or CMD_R on a cache hit.
- Transmit rule: each character occupies one cycle with i_uart_send_ready=1. In that cycle o_uart_send_pulse=1 and o_uart_dat is valid; the FSM advances on that edge. While ready=0, the FSM stalls and the pulse stays 0.
- Hex encoding is lowercase only: nibble n maps to 0x30+n for n≤9 and 0x57+n for n≥10.
- Write completes after the last data character is sent: go to ACK.
- Read: after `R`, wait in RX_HI, then RX_LO, for received hex characters.
  - Accepted characters: `0`-`9` and `a`-`f`. Any other received character is ignored.
  - RX characters arriving in any other state are discarded.
- ACK: o_ack=1 for exactly one cycle, then IDLE. o_err is valid in the same cycle.
- Timeout: a counter restarts on entry to RX_HI and on entry to RX_LO. When it reaches TIMEOUT: go to ACK with o_err=1, set o_dat=0xff, and invalidate the cache.
- Changes of i_target_reset during a transaction wait until the FSM is in IDLE.
- Async reset mid-transaction aborts immediately and no o_ack is issued; the requester must re-issue.

## Timing
- Write with L, all ready=1: 8 send cycles. o_ack is in the cycle after the last send pulse, so latency is 10 cycles from i_req high in IDLE.
- Read with L: 6 send cycles. o_ack follows the second accepted RX character by 1 cycle. o_dat updates on the same edge that raises o_ack.
- The requester drops i_req on the edge where it samples o_ack=1, so IDLE never re-accepts the completed request.
- The transmitter is expected to drop ready the cycle after a pulse; the block never issues a pulse while ready=0.

## Configuration
- UART_CMD_MASTER_ADDR_CACHE_EN defined: track next_addr/valid. After each successful access, set next_addr = addr+1 with 16-bit wrap (0xffff→0x0000) and set valid=1.
  - A request with i_addr==next_addr while valid skips `L` and the address nibbles.
  - valid is cleared by reset, by a timeout, and by any RST_CHAR send.
- Without the macro: `L` plus 4 address nibbles are always sent. No cache registers exist.

## Structure
- Package uart_cmd_pkg holds:
  - Character constants: `L`, `W`, `R`, `,`, `.`, `0`, `a`.
  - The FSM state enum.
- One sub-module, uart_hex_codec (combinational): nibble→ASCII encoding, plus ASCII→nibble decoding with a valid flag. Used for both TX and RX.

## Test plan
- Write 0x1a00←0x4d, ready=1 → TX "L1a00W4d", o_ack 1 cycle after the last pulse, o_err=0.
- Read 0x1234, reply "x" then "b" then "7" → TX "L1234R", "x" ignored, o_dat=0xb7, o_ack=1, o_err=0.
- Read with no reply, TIMEOUT=50 → o_ack with o_err=1 and o_dat=0xff, 50 cycles after the last TX pulse (±1).
- Toggle i_target_reset 0→1 while a write is pending in IDLE → `,` sent before `L`. Toggle 1→0 → `.` sent.
- Cache on: write 0xffff, then write 0x0000 → second transaction sends "W.." only. After a timeout, the next access sends "L" again.
- Ready toggling every other cycle during a write → exactly 8 pulses, none while ready=0, and the character sequence is unchanged.
